// File: rtl/vga_frame_capture.sv
// Frame grabber: converts active VGA pixels to 8-bit grayscale and writes the
// top-left IMG_W x IMG_H window into a single-port frame RAM, one frame per request.
module vga_frame_capture #(
    parameter int IMG_W  = 100,
    parameter int IMG_H  = 100,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_en,
    input  logic              hsync,
    input  logic              vsync,
    input  logic              blank_b,
    input  logic [7:0]        pix_r,
    input  logic [7:0]        pix_g,
    input  logic [7:0]        pix_b,
    input  logic              capture_req,
    output logic              capture_busy,
    output logic              capture_done,
    output logic              capture_err,
    output logic [ADDR_W-1:0] ram_address,
    output logic [31:0]       ram_data,
    output logic              ram_wren
);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_CAPTURE, S_DONE, S_ABORT} state_t;

    localparam logic [9:0] X_LIM = 10'(IMG_W);
    localparam logic [9:0] Y_LIM = 10'(IMG_H);

    state_t            state_q, state_d;
    logic              hs_q, vs_q, bl_q;
    logic [9:0]        x_q, y_q;
    logic [ADDR_W-1:0] addr_q;
    logic              fs, le, active, in_window, wr_fire;
    logic [9:0]        gray_sum;

    // hs_q is kept for debug visibility only; this sink marks it as intentionally unread.
    logic hs_dbg_unused;
    assign hs_dbg_unused = hs_q;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_q <= 1'b1;
            vs_q <= 1'b1;
            bl_q <= 1'b0;
        end else if (pix_en) begin
            hs_q <= hsync;
            vs_q <= vsync;
            bl_q <= blank_b;
        end
    end

    assign fs        = pix_en & vs_q & ~vsync;
    assign le        = pix_en & bl_q & ~blank_b;
    assign active    = pix_en & blank_b;
    assign in_window = (x_q < X_LIM) && (y_q < Y_LIM);
    assign wr_fire   = (state_q == S_CAPTURE) && active && in_window && !fs;
    assign gray_sum  = {2'b00, pix_r} + {1'b0, pix_g, 1'b0} + {2'b00, pix_b};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        capture_busy = (state_q != S_IDLE);
        capture_done = 1'b0;
        capture_err  = 1'b0;
        case (state_q)
            S_IDLE:    if (capture_req) state_d = S_ARM;
            S_ARM:     if (fs) state_d = S_CAPTURE;
            S_CAPTURE: begin
                if (fs)
                    state_d = S_ABORT;
                else if (le && (y_q + 10'd1 == Y_LIM))
                    state_d = S_DONE;
            end
            S_DONE: begin
                capture_done = 1'b1;
                state_d      = S_IDLE;
            end
            S_ABORT: begin
                capture_err = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= '0;
        end else if (state_q == S_ARM && fs) begin
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= '0;
        end else if (state_q == S_CAPTURE && !fs) begin
            if (active) begin
                if (x_q != 10'h3FF) x_q <= x_q + 10'd1;
                if (in_window)      addr_q <= addr_q + ADDR_W'(1);
            end else if (le) begin
                x_q <= '0;
                y_q <= y_q + 10'd1;
            end
        end
    end

    // Address and data are registered alongside the strobe so all three align at the RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_wren    <= 1'b0;
            ram_address <= '0;
            ram_data    <= '0;
        end else begin
            ram_wren <= wr_fire;
            if (wr_fire) begin
                ram_address <= addr_q;
                ram_data    <= {24'h0, gray_sum[9:2]};
            end
        end
    end

endmodule

// File: doc/vga_frame_capture.md
# vga_frame_capture

Video-input frame grabber: the write-side counterpart of the VGA output path. It watches a VGA-style pixel stream (hsync, vsync, blank_b, 8-bit RGB), converts each active pixel to 8-bit grayscale, and writes the top-left IMG_W×IMG_H window into the single-port frame RAM (`ram2`-style, 32-bit data). The display path later reads that RAM at address y*IMG_W + x. The block captures one frame per request.

## Interface
Parameters:
- IMG_W, 100, captured window width in pixels
- IMG_H, 100, captured window height in lines
- ADDR_W, 14, RAM address width; must satisfy IMG_W*IMG_H ≤ 2^ADDR_W

Ports:
- clk  in  1  system clock; sole clock
- rst  in  1  asynchronous, active-high reset
- pix_en  in  1  pixel strobe; stream inputs are sampled only in cycles where pix_en=1
- hsync  in  1  horizontal sync, active low
- vsync  in  1  vertical sync, active low
- blank_b  in  1  1 = active video pixel
- pix_r, pix_g, pix_b  in  8 each  pixel colour
- capture_req  in  1  single-cycle request to grab the next frame
- capture_busy  out  1  high from request accept until return to IDLE
- capture_done  out  1  one-cycle pulse, frame written
- capture_err  out  1  one-cycle pulse, frame aborted
- ram_address  out  ADDR_W  write address
- ram_data  out  32  {24'h0, gray}
- ram_wren  out  1  write enable, one cycle per pixel

## Operation
- Stream inputs are synchronous to clk. Registered previous samples hs_q, vs_q, bl_q update only on pix_en. Reset values: 1, 1, 0.
- Frame start (fs): pix_en & vs_q & ~vsync, i.e. a vsync falling edge. Line end (le): pix_en & bl_q & ~blank_b, i.e. a blank_b falling edge. hsync is registered for debug only; it does not drive capture.
- Counters: x and y are 10 bits each; the write address counter is ADDR_W bits.
- State machine:
  - IDLE: busy=0. capture_req → ARM. capture_req is ignored in every other state.
  - ARM: busy=1, no writes. On fs: x=0, y=0, addr=0, → CAPTURE.
  - CAPTURE: on an active sample (pix_en & blank_b): if x<IMG_W and y<IMG_H, issue a write at addr and then addr++. x increments, saturating at 1023.
  - CAPTURE, on le: x=0, y++. If the new y equals IMG_H → DONE.
  - CAPTURE, on fs: capture_err pulses → IDLE. The counters are not reused.
  - DONE: capture_done=1 for exactly one cycle → IDLE.
- Gray arithmetic: gray = (r + 2g + b) >> 2. Compute with a 10-bit sum; the result is the low 8 bits after the shift and never overflows.
- ram_data upper 24 bits are always 0.
- Reset, asynchronous at any time including mid-frame:
  - state=IDLE, all counters 0, all outputs 0 (ram_address=0, ram_data=0).
  - Any pending write is dropped. Already-written RAM words are left as-is.

## Timing
- Write latency: a pixel sampled in cycle N produces ram_wren=1 in N+1, with ram_address and ram_data registered in the same cycle.
- ram_wren is high for exactly one cycle per accepted pixel. Back-to-back pix_en gives back-to-back writes.
- The last write (addr IMG_W*IMG_H-1) always completes before capture_done. le follows the last active pixel by at least one pix_en cycle.
- capture_done and capture_err are mutually exclusive and never asserted in the same cycle as capture_req acceptance.
- capture_busy rises the cycle after capture_req is accepted. It falls in the cycle after the DONE or error cycle.
- fs in ARM and fs in CAPTURE are both evaluated on the same sample. The CAPTURE rule (error) applies only when already in CAPTURE.

## Test plan
1. Reset: assert rst mid-CAPTURE with writes pending → next cycle ram_wren=0, busy=0, done=0, err=0, ram_address=0. No further writes until a new capture_req.
2. Small frame: IMG_W=4, IMG_H=3, stream of 6 active pixels × 5 lines, pix_en every cycle.
   - Expect exactly 12 writes, addresses 0..11 in order, row-major.
   - Expect capture_done once, after the write to address 11.
3. Gray math:
   - RGB (255,255,255) → ram_data=32'h000000FF.
   - RGB (0x10,0x20,0x30) → 32'h00000020.
   - RGB (3,0,0) → 32'h00000000.
4. Early vsync: IMG_H=3, vsync falls after 2 lines in CAPTURE → capture_err one-cycle pulse, no capture_done, busy falls, at most 8 writes.
5. Gaps and request handling:
   - pix_en pulses every 2nd cycle → writes only on cycles following a pix_en sample.
   - capture_req pulsed during ARM and CAPTURE → ignored; a single done per frame.
6. Mid-line arm: capture_req arrives mid-frame → no writes until the next vsync falling edge; the first write goes to address 0.
